// File: rtl/cic_integrator_decimator.sv
// Integrator half of a CIC decimator: STAGES wrap-around accumulators at the input
// rate, with the last stage sampled once every DEC_FACTOR enabled cycles.
module cic_integrator_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 3,
    parameter int DEC_FACTOR = 4,
    parameter int ACC_WIDTH  = 22
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           sync_clr,
    input  logic signed [DATA_WIDTH-1:0]   in,
    output logic signed [ACC_WIDTH-1:0]    out,
    output logic                           out_valid,
    output logic [$clog2(DEC_FACTOR)-1:0]  phase
);

    localparam int PW = $clog2(DEC_FACTOR);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DEC_FACTOR - 1);

    logic signed [ACC_WIDTH-1:0] acc      [STAGES];
    logic signed [ACC_WIDTH-1:0] acc_next [STAGES];
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic                        last_phase;

    assign in_ext     = ACC_WIDTH'(in);
    assign last_phase = (phase == LAST_PHASE);

    // Each stage adds the registered value of the stage before it, so stage k lags
    // stage k-1 by one enabled cycle; the comb half downstream cancels the wrap.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            acc_next[k] = acc[k];
        end
        acc_next[0] = acc[0] + in_ext;
        for (int k = 1; k < STAGES; k++) begin
            acc_next[k] = acc[k] + acc[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulators are state, not storage -- every entry must be reset,
            // otherwise the first decimated samples after reset inherit garbage.
            for (int k = 0; k < STAGES; k++) begin
                acc[k] <= '0;
            end
            phase     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (sync_clr) begin
            for (int k = 0; k < STAGES; k++) begin
                acc[k] <= '0;
            end
            phase     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (en) begin
                acc <= acc_next;
                if (last_phase) begin
                    phase     <= '0;
                    out       <= acc_next[STAGES-1];
                    out_valid <= 1'b1;
                end else begin
                    phase <= phase + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// Directed bench for cic_integrator_decimator: the driver queues expected decimated
// samples, an independent monitor pops and compares them on every out_valid strobe.
module tb_cic_integrator_decimator;

    logic               clk;
    logic               rst;
    logic               en;
    logic               sync_clr;
    logic signed [15:0] in_s;
    logic signed [21:0] out_s;
    logic               out_valid;
    logic [1:0]         phase;

    typedef struct {
        logic signed [21:0] value;
        int                 cycle;
    } exp_t;

    exp_t sb[$];
    exp_t item;
    int   cyc;
    int   checks;
    int   errors;
    logic signed [21:0] hold_out;

    cic_integrator_decimator #(
        .DATA_WIDTH(16), .STAGES(3), .DEC_FACTOR(4), .ACC_WIDTH(22)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
        .in(in_s), .out(out_s), .out_valid(out_valid), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation, value and clock.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", 1, 0);
            end else begin
                item = sb.pop_front();
                check("out_value", longint'(out_s), longint'(item.value));
                check("out_cycle", cyc, item.cycle);
            end
        end
    end

    function automatic logic signed [21:0] wrap22(input longint v);
        logic [63:0] t;
        t = v;
        return t[21:0];
    endfunction

    function automatic longint binom3(input longint n);
        return n * (n - 1) * (n - 2) / 6;
    endfunction

    // One enabled sample; when it lands on the last phase, the strobe is expected
    // in the very next cycle carrying e.
    task automatic send(input logic signed [15:0] x, input int ph, input logic signed [21:0] e);
        check("phase", longint'(phase), ph);
        en = 1'b1;
        in_s = x;
        if (ph == 3) sb.push_back('{e, cyc + 1});
        @(negedge clk);
        en = 1'b0;
        in_s = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic clear(input logic en_val);
        sync_clr = 1'b1;
        en = en_val;
        in_s = 16'sd1;
        @(negedge clk);
        sync_clr = 1'b0;
        en = 1'b0;
        in_s = '0;
        check("clr_out", longint'(out_s), 0);
        check("clr_phase", longint'(phase), 0);
        check("clr_valid", longint'(out_valid), 0);
    endtask

    task automatic step_run(input int n);
        logic signed [21:0] step_exp [3];
        step_exp = '{22'sd4, 22'sd56, 22'sd220};
        for (int i = 0; i < n; i++) send(16'sd1, i % 4, step_exp[(i / 4) % 3]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [21:0] imp_exp [3];
        checks = 0;
        errors = 0;
        cyc = 0;
        rst = 1'b1;
        en = 1'b0;
        sync_clr = 1'b0;
        in_s = '0;
        repeat (2) @(negedge clk);
        check("rst_out", longint'(out_s), 0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_phase", longint'(phase), 0);
        rst = 1'b0;
        @(negedge clk);

        // Step: 4, 56, 220 at 4-clock spacing
        step_run(12);
        drain();

        // Impulse: 3, 21, 55
        clear(1'b0);
        imp_exp = '{22'sd3, 22'sd21, 22'sd55};
        for (int i = 0; i < 12; i++) send(i == 0 ? 16'sd1 : 16'sd0, i % 4, imp_exp[i / 4]);
        drain();

        // Negative step: -4, -56
        clear(1'b0);
        for (int i = 0; i < 8; i++) send(-16'sd1, i % 4, i < 4 ? -22'sd4 : -22'sd56);
        drain();

        // Full-scale step wraps modulo 2^22
        clear(1'b0);
        for (int i = 0; i < 64; i++) send(16'sd32767, i % 4, wrap22(32767 * binom3(i + 1)));
        drain();

        // Gapped enable: same values, strobes 8 clocks apart, state frozen in gaps
        clear(1'b0);
        hold_out = '0;
        for (int i = 0; i < 12; i++) begin
            send(16'sd1, i % 4, (i < 4) ? 22'sd4 : (i < 8) ? 22'sd56 : 22'sd220);
            if (i % 4 == 3) hold_out = (i < 4) ? 22'sd4 : (i < 8) ? 22'sd56 : 22'sd220;
            @(negedge clk);
            check("gap_phase_hold", longint'(phase), (i + 1) % 4);
            check("gap_out_hold", longint'(out_s), longint'(hold_out));
            check("gap_no_strobe", longint'(out_valid), 0);
        end
        drain();

        // sync_clr at phase 2, then restart from zero
        clear(1'b0);
        step_run(6);
        drain();
        check("pre_clr_out", longint'(out_s), 4);
        clear(1'b1);
        step_run(4);
        drain();

        // sync_clr coincident with phase 3 and en: strobe suppressed
        clear(1'b0);
        for (int i = 0; i < 3; i++) send(16'sd1, i, 22'sd0);
        check("pre_clr_phase", longint'(phase), 3);
        clear(1'b1);
        @(negedge clk);
        check("clr_suppress", longint'(out_valid), 0);
        step_run(4);
        drain();

        // Async reset between edges at phase 1
        clear(1'b0);
        step_run(5);
        drain();
        check("pre_rst_phase", longint'(phase), 1);
        #2 rst = 1'b1;
        #1;
        check("async_out", longint'(out_s), 0);
        check("async_valid", longint'(out_valid), 0);
        check("async_phase", longint'(phase), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step_run(12);
        drain();

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_integrator_decimator.md
# cic_integrator_decimator

Integrator-and-decimate front half of the CIC decimation path. It runs a cascade of `STAGES` wrap-around accumulators at the input sample rate and emits one full-width sample every `DEC_FACTOR` enabled cycles. The output feeds the comb (differencing) stage, which completes the CIC filter at the low rate. Accumulators are deliberately modular: the downstream comb stage cancels wrap-around, so no saturation is applied here.

## Interface
- `DATA_WIDTH`, 16, input sample width (signed two's complement).
- `STAGES`, 3, number of cascaded integrators (1..6).
- `DEC_FACTOR`, 4, decimation ratio R (2..256).
- `ACC_WIDTH`, 22, accumulator/output width. Must be ≥ DATA_WIDTH + STAGES·ceil(log2(DEC_FACTOR)); the default is 16+3·2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, **asynchronous, active-high**.
- `en`  in  1  sample enable. One input sample is consumed per cycle with en=1.
- `sync_clr`  in  1  synchronous clear of accumulators, phase counter and output. Has priority over en.
- `in`  in  DATA_WIDTH  signed input sample, valid when en=1.
- `out`  out  ACC_WIDTH  signed decimated sample (last-stage accumulator).
- `out_valid`  out  1  one-cycle strobe marking a new `out`.
- `phase`  out  ceil(log2(DEC_FACTOR))  current decimation phase (0..DEC_FACTOR-1), for debug/alignment.

## Operation
- Registers: `acc[1..STAGES]` (ACC_WIDTH, signed), `phase` counter, `out`, `out_valid`.
- On a cycle with en=1 (and sync_clr=0):
  - `acc[1] <= acc[1] + sext(in)`.
  - `acc[k] <= acc[k] + acc[k-1]` for k ≥ 2, using the pre-edge (registered) value of acc[k-1], so each stage adds one cycle of pipeline.
- All additions are modulo 2^ACC_WIDTH. Carries out are dropped and no overflow flag exists.
- Phase counter advances 0→1→…→DEC_FACTOR-1→0, only on en=1 cycles.
- Decimation: on an en=1 cycle with phase==DEC_FACTOR-1, `out` loads the new (post-update) value of acc[STAGES], i.e. `acc[STAGES] + acc[STAGES-1]` (or `acc[1] + sext(in)` when STAGES=1). `out_valid`=1 on the following cycle only.
- en=0: all state, `out` and `phase` hold. `out_valid`=0.
- sync_clr=1: acc[*], phase and out go to 0 and out_valid=0 on that edge, regardless of en. The input on that cycle is discarded.
- rst=1 (asynchronous, any time including mid-decimation-period): acc[*]=0, phase=0, out=0, out_valid=0 immediately. After release, the first en=1 cycle is phase 0.

## Timing
- Reset values: out=0, out_valid=0, phase=0.
- Pipeline: a sample taken at en-cycle n first reaches acc[k] after en-cycle n+k-1.
- From reset/clear with constant input x: acc[STAGES] after n en-cycles equals x·C(n, STAGES) mod 2^ACC_WIDTH.
- out_valid rises the cycle after the en-cycle where phase==DEC_FACTOR-1. It pulses once per DEC_FACTOR en-cycles.
- Back-to-back en: outputs are exactly DEC_FACTOR clocks apart. Gaps in en stretch the spacing but never drop or duplicate a sample.
- sync_clr and en in the same cycle: the clear wins. No out_valid is generated even if phase was DEC_FACTOR-1.

## Test plan
- Step, defaults: rst pulse, then in=1 with en=1 continuously. Required: out=4, 56, 220 on the first three out_valid strobes, at clocks 4, 8, 12 after the first en, with phase cycling 0..3.
- Impulse, defaults: in=1 for one en cycle, then 0. Required: out=3, 21, 55 on the first three strobes.
- Negative/wrap: in=-1 continuously. Required: out=-4 then -56. In a second run, in=32767 continuously for 64 en cycles: every out equals 32767·C(n,3) mod 2^22, interpreted as signed.
- Gapped enable: step stimulus with en toggling 1,0,1,0. Required: the same out values as the step test, out_valid every 8 clocks, and state frozen during en=0.
- sync_clr mid-period: step run, assert sync_clr at phase=2, then resume. Required: phase=0, out=0 next cycle, no strobe, then out=4 after 4 further en cycles. Repeat with sync_clr coincident with phase=3 and en=1: that strobe is suppressed.
- Async reset mid-run: assert rst between clock edges during phase=1. Required: out=0, out_valid=0, phase=0 before the next edge. After release, the step sequence 4, 56, 220 restarts.
